// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic inter-stage pipeline register.
package pipe_pkg;

  localparam int unsigned PIPE_CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_ONE,
    PS_TWO
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle between two pipeline stages.
interface pipe_stage_elastic_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush and saturating stall/drop performance counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CW    = PIPE_CW_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  pipe_stage_elastic_if.slave  bus,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CW-1:0]        stall_cnt,
  output logic [CW-1:0]        drop_cnt
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;

  logic main_v_c;
  logic skid_v_c;
  logic in_ready_c;
  logic accept_c;
  logic fire_c;

  // State register plus payload and registered ready (skid mode).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  // Occupancy decode and handshake qualifiers.
  always_comb begin
    main_v_c   = (state_q != PS_EMPTY);
    skid_v_c   = (state_q == PS_TWO);
    in_ready_c = (SKID != 0) ? rdy_q : (!main_v_c || bus.out_ready);
    accept_c   = bus.in_valid && in_ready_c;
    fire_c     = main_v_c && bus.out_ready;
  end

  // Next occupancy; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: if (accept_c) state_d = PS_ONE;
        PS_ONE: begin
          if (accept_c && !fire_c)      state_d = (SKID != 0) ? PS_TWO : PS_ONE;
          else if (!accept_c && fire_c) state_d = PS_EMPTY;
        end
        PS_TWO:   if (fire_c) state_d = PS_ONE;
        default:  state_d = PS_EMPTY;
      endcase
    end
    rdy_d = (state_d != PS_TWO);
  end

  // Payload movement; vacated slots are zeroed so out_data reads 0 when idle.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else begin
      unique case (state_q)
        PS_EMPTY: if (accept_c) main_d = bus.in_data;
        PS_ONE: begin
          if (accept_c && fire_c)       main_d = bus.in_data;
          else if (accept_c)            skid_d = bus.in_data;
          else if (fire_c)              main_d = '0;
        end
        PS_TWO: begin
          if (fire_c) begin
            main_d = skid_q;
            skid_d = '0;
          end
        end
        default: begin
          main_d = '0;
          skid_d = '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = main_v_c;
  assign bus.out_data  = main_q;

  sat_counter #(.CW(CW)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (main_v_c && !bus.out_ready),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  // A flush counts as a drop only when it actually discards a beat.
  sat_counter #(.CW(CW)) u_drop_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush && ((main_v_c && !fire_c) || skid_v_c || accept_c)),
    .clr   (cnt_clr),
    .count (drop_cnt)
  );

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised inter-stage pipeline register for the processor datapath, replacing hand-written per-stage latches (IF/ID, ID/EX, EX/MEM) with one generic block. Carries a WIDTH-bit packed payload under a valid/ready handshake instead of a bare enable, with an optional two-entry skid buffer that keeps full throughput while registering the upstream ready path. Supports synchronous flush for branch/jump squash, and has saturating stall and drop counters for pipeline performance analysis.

## Interface
- WIDTH, 32, payload width in bits (packed stage control and data bundle)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CW, 16, width of each performance counter
- CLK  input  1  clock, rising edge
- nRST  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage accepts the beat this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  downstream beat present
- out_ready  input  1  downstream accepts the beat this cycle
- out_data  output  WIDTH  downstream payload
- flush  input  1  synchronous squash of all held entries
- cnt_clr  input  1  synchronous clear of both counters
- stall_cnt  output  CW  cycles with out_valid=1 and out_ready=0
- drop_cnt  output  CW  flushes that discarded at least one valid entry

## Operation
- Accept = in_valid && in_ready; fire = out_valid && out_ready.
- Storage: main register (main_v, main_d) drives out_valid/out_data directly; skid register (skid_v, skid_d) present only when SKID=1.
- SKID=1 state (pipe_state_t): EMPTY (main_v=0), ONE (main_v=1, skid_v=0), TWO (both valid). in_ready = (state != TWO), a register output.
  - EMPTY: accept -> ONE, main_d <= in_data.
  - ONE: accept && fire -> ONE, main_d <= in_data; accept && !fire -> TWO, skid_d <= in_data; !accept && fire -> EMPTY.
  - TWO: fire -> ONE, main_d <= skid_d; otherwise hold. No accept possible.
- SKID=0: in_ready = !main_v || out_ready (combinational). Accept loads main; fire without accept clears main_v.
- Flush (priority over every other event): next state EMPTY, main_v and skid_v cleared, main_d and skid_d cleared to 0. A beat accepted in the flush cycle is discarded; a beat fired in the flush cycle completes downstream normally.
- Held payload never changes while out_valid=1 and out_ready=0 (AXI-style stability); out_data = 0 whenever out_valid=0.
- stall_cnt: +1 per cycle with out_valid && !out_ready; saturates at 2^CW-1.
- drop_cnt: +1 per flush cycle where (main_v && !fire) || skid_v || accept; saturates.
- cnt_clr wins over a coincident increment; counters read 0 next cycle.

## Timing
- Reset (nRST low, async): state EMPTY, out_valid=0, out_data=0, in_ready=1, stall_cnt=0, drop_cnt=0, skid cleared.
- Latency in->out: 1 cycle (beat accepted at edge N is on out_data after edge N, visible cycle N+1).
- Throughput: 1 beat/cycle in both modes while out_ready=1.
- SKID=1: in_ready deasserts 1 cycle after the first stalled accept; reasserts the cycle after a TWO->ONE fire; no combinational in_ready <- out_ready path.
- Flush: out_valid=0 and in_ready=1 the cycle after flush asserts; sustained flush keeps the stage EMPTY.
- Reset released mid-stream: stage starts EMPTY; upstream must re-present beats.

## Structure
- Shared package pipe_pkg: typedef enum pipe_state_t {PS_EMPTY, PS_ONE, PS_TWO}; localparam PIPE_CW_DEFAULT = 16.
- Sub-module sat_counter (parameter CW; inputs inc, clr; output count), instantiated twice for stall_cnt and drop_cnt.
- Stage payload structs (e.g. ID/EX bundle) stay in cpu_types_pkg; callers pack them to WIDTH.

## Test plan
- Reset, then stream 0x1,0x2,0x3 with out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, each 1 cycle after accept; in_ready stays 1.
- SKID=1: send 0xA,0xB with out_ready=0 -> state TWO, in_ready=0 on the third cycle, out_data=0xA stable; raise out_ready -> 0xA then 0xB, in_ready=1 the cycle after 0xA fires; stall_cnt equals stalled cycles.
- Flush in TWO with in_valid=1 (in_ready=0) -> next cycle out_valid=0, out_data=0, in_ready=1, drop_cnt=1.
- Flush in EMPTY with in_valid=0 -> drop_cnt unchanged; flush with an accepting beat 0x5 -> 0x5 never appears, drop_cnt +1.
- CW=4, out_ready=0 for 20 cycles with a held beat -> stall_cnt saturates at 15; cnt_clr together with a stall cycle -> stall_cnt=0 next cycle.
- SKID=0: out_ready toggling 1,0,1 with continuous input -> in_ready follows out_ready in the same cycle while main_v=1, no beat lost or duplicated.
